// File: rtl/axi_write_master.sv
// Command-driven AXI3 write master: one burst in flight, AW then W (generated wlast) then B,
// with one completion record per command including illegal-command and response-timeout outcomes.
module axi_write_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              aclk,
  input  logic              areset,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [1:0]        cmd_burst,
  input  logic [ID_W-1:0]   cmd_id,
  // beat source
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [3:0]        s_strb,
  // AW
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [ID_W-1:0]   awid,
  output logic [3:0]        awlen,
  output logic [1:0]        awburst,
  output logic [2:0]        awsize,
  output logic [1:0]        awlock,
  output logic [1:0]        awcache,
  output logic [1:0]        awprot,
  // W
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  // B
  input  logic              bvalid,
  output logic              bready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  // completion
  output logic              done_valid,
  output logic [1:0]        done_status,
  output logic [1:0]        done_bresp
);

  localparam int              TO_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state;
  logic [3:0]      beat;
  logic [TO_W-1:0] tmo_cnt;

  logic            cmd_fire;
  logic            cmd_legal;
  logic            w_fire;
  logic [13:0]     incr_end;

  assign awsize  = 3'b010;
  assign awlock  = 2'b00;
  assign awcache = 2'b00;
  assign awprot  = 2'b00;

  assign cmd_ready = (state == IDLE) && !areset;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Byte offset one past the last beat within the 4KB page; a value above 4096 crosses it.
  assign incr_end = {2'b00, cmd_addr[11:0]} + {6'd0, {2'b00, cmd_len} + 6'd1, 2'b00};

  // NOTE: give every always_comb output a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    cmd_legal = 1'b1;
    case (cmd_burst)
      2'b01:   cmd_legal = (incr_end <= 14'd4096);
      2'b10:   cmd_legal = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                           (cmd_len == 4'd7) || (cmd_len == 4'd15);
      2'b11:   cmd_legal = 1'b0;
      default: cmd_legal = 1'b1;
    endcase
  end

  // W channel is a straight passthrough of the beat source while in DATA.
  assign wvalid  = (state == DATA) && s_valid;
  assign s_ready = (state == DATA) && wready;
  assign wdata   = (state == DATA) ? s_data : '0;
  assign wstrb   = (state == DATA) ? s_strb : '0;
  assign wlast   = (state == DATA) && (beat == awlen);
  assign w_fire  = wvalid && wready;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      awvalid     <= 1'b0;
      bready      <= 1'b0;
      done_valid  <= 1'b0;
      done_status <= 2'b00;
      done_bresp  <= 2'b00;
      awaddr      <= '0;
      awid        <= '0;
      awlen       <= '0;
      awburst     <= '0;
      beat        <= '0;
      tmo_cnt     <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            awaddr  <= cmd_addr;
            awid    <= cmd_id;
            awlen   <= cmd_len;
            awburst <= cmd_burst;
            if (cmd_legal) begin
              awvalid <= 1'b1;
              state   <= ADDR;
            end else begin
              done_valid  <= 1'b1;
              done_status <= 2'b10;
              done_bresp  <= 2'b00;
            end
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            beat    <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (w_fire) begin
            if (wlast) begin
              bready  <= 1'b1;
              tmo_cnt <= '0;
              state   <= RESP;
            end else begin
              beat <= beat + 4'd1;
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            done_valid  <= 1'b1;
            done_bresp  <= bresp;
            done_status <= (bresp[1] || (bid != awid)) ? 2'b01 : 2'b00;
            state       <= IDLE;
          end else if (tmo_cnt == TO_LAST) begin
            bready      <= 1'b0;
            done_valid  <= 1'b1;
            done_bresp  <= 2'b00;
            done_status <= 2'b11;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
